// File: rtl/miner_spi_host.sv
// SPI host for the miner command protocol: loads one job, polls the miner status
// and fetches the winning hash and nonce. A small byte engine does the mode-0 bit timing.
module miner_spi_byte_engine #(
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] tx_byte,
  input  logic       last,
  input  logic       miso,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       sck,
  output logic       mosi,
  output logic       ssel
);
  typedef enum logic [1:0] {E_IDLE, E_LOW, E_HIGH, E_GAP} eng_state_e;

  eng_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d;
  logic        last_q, last_d, sck_q, sck_d, mosi_q, mosi_d, ssel_q, ssel_d;
  logic [15:0] gap_len_s;
  logic        div_end_s;

  // The final byte of a frame only waits CLK_DIV so ssel rises that long after the last fall.
  assign gap_len_s = last_q ? 16'(CLK_DIV) : 16'(BYTE_GAP);
  assign div_end_s = (cnt_q == 16'(CLK_DIV - 1));
  assign byte_done = (state_q == E_GAP) && (cnt_q == gap_len_s - 16'd1);
  assign rx_byte   = rx_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign ssel      = ssel_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    last_d  = last_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    ssel_d  = ssel_q;
    case (state_q)
      E_IDLE: begin
        cnt_d = 16'd0;
        if (go) begin
          state_d = E_LOW;
          bit_d   = 3'd0;
          tx_d    = tx_byte;
          mosi_d  = tx_byte[7];
          last_d  = last;
          ssel_d  = 1'b0;
        end else begin
          state_d = E_IDLE;
        end
      end
      E_LOW: begin
        if (div_end_s) begin
          state_d = E_HIGH;
          cnt_d   = 16'd0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], miso};
        end else begin
          state_d = E_LOW;
        end
      end
      E_HIGH: begin
        if (div_end_s) begin
          cnt_d = 16'd0;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = E_GAP;
          end else begin
            state_d = E_LOW;
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
          end
        end else begin
          state_d = E_HIGH;
        end
      end
      E_GAP: begin
        if (byte_done && go) begin
          state_d = E_LOW;
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          tx_d    = tx_byte;
          mosi_d  = tx_byte[7];
          last_d  = last;
        end else if (byte_done) begin
          state_d = E_IDLE;
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          state_d = E_GAP;
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= E_IDLE;
      cnt_q   <= 16'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      ssel_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ssel_q  <= ssel_d;
    end
  end
endmodule

module miner_spi_host #(
  parameter int CLK_DIV  = 4,
  parameter int BYTE_GAP = 8,
  parameter int POLL_GAP = 256,
  parameter int POLL_MAX = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] first_stage_hash,
  input  logic [95:0]  input_M,
  input  logic [255:0] prev_blk,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         timeout,
  output logic [31:0]  nonce,
  output logic [255:0] winner_H,
  output logic         sck,
  output logic         mosi,
  output logic         ssel,
  input  logic         miso
);
  localparam logic [7:0] CMD_START = 8'hA2;
  localparam logic [7:0] CMD_GET   = 8'hA4;
  localparam logic [7:0] ST_DONE   = 8'hA5;
  localparam logic [7:0] ST_FOUND  = 8'hA6;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_POLL_WAIT, S_POLL, S_READ, S_FINISH} state_e;

  state_e        state_q, state_d;
  logic [615:0]  frame_q, frame_d;
  logic [7:0]    idx_q, idx_d;
  logic          kick_q, kick_d;
  logic [15:0]   poll_cnt_q, poll_cnt_d;
  logic [15:0]   wait_q, wait_d;
  logic          busy_q, busy_d, done_q, done_d, found_q, found_d, timeout_q, timeout_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [255:0]  winner_q, winner_d;
  logic          eng_go_s, eng_last_s, byte_done_s, frame_end_s;
  logic [7:0]    eng_tx_s, rx_s, frame_len_s;

  miner_spi_byte_engine #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP)) u_engine (
    .clk(clk), .reset(reset), .go(eng_go_s), .tx_byte(eng_tx_s), .last(eng_last_s),
    .miso(miso), .byte_done(byte_done_s), .rx_byte(rx_s), .sck(sck), .mosi(mosi), .ssel(ssel)
  );

  // kick_q launches the first byte of a frame; later bytes chain off byte_done.
  always_comb begin
    case (state_q)
      S_LOAD:  frame_len_s = 8'd77;
      S_READ:  frame_len_s = 8'd38;
      default: frame_len_s = 8'd1;
    endcase
    frame_end_s = byte_done_s && (idx_q == frame_len_s - 8'd1);
    eng_go_s    = kick_q || (byte_done_s && !frame_end_s);
    eng_tx_s    = kick_q ? frame_q[615:608] : frame_q[607:600];
    eng_last_s  = kick_q ? (frame_len_s == 8'd1) : (idx_q + 8'd2 == frame_len_s);
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = byte_done_s ? {frame_q[607:0], 8'h00} : frame_q;
    kick_d     = 1'b0;
    poll_cnt_d = poll_cnt_q;
    wait_d     = wait_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    found_d    = found_q;
    timeout_d  = timeout_q;
    nonce_d    = nonce_q;
    winner_d   = winner_q;
    if (kick_q) begin
      idx_d = 8'd0;
    end else if (byte_done_s && !frame_end_s) begin
      idx_d = idx_q + 8'd1;
    end else begin
      idx_d = idx_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          frame_d    = {CMD_START, first_stage_hash, input_M, prev_blk};
          kick_d     = 1'b1;
          busy_d     = 1'b1;
          found_d    = 1'b0;
          timeout_d  = 1'b0;
          poll_cnt_d = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (frame_end_s) begin
          state_d = S_POLL_WAIT;
          wait_d  = 16'd0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_POLL_WAIT: begin
        if (wait_q == 16'(POLL_GAP - 1)) begin
          state_d = S_POLL;
          frame_d = '0;
          kick_d  = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_POLL: begin
        if (frame_end_s) begin
          if (rx_s == ST_FOUND) begin
            state_d = S_READ;
            frame_d = {CMD_GET, 608'd0};
            kick_d  = 1'b1;
          end else if (rx_s == ST_DONE) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            wait_d     = 16'd0;
            if (poll_cnt_q + 16'd1 == 16'(POLL_MAX)) begin
              state_d   = S_FINISH;
              done_d    = 1'b1;
              busy_d    = 1'b0;
              timeout_d = 1'b1;
            end else begin
              state_d = S_POLL_WAIT;
            end
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_READ: begin
        // The first two rx bytes only carry miner pipeline lag.
        if (byte_done_s && idx_q >= 8'd2 && idx_q <= 8'd33) begin
          winner_d = {winner_q[247:0], rx_s};
        end else if (byte_done_s && idx_q >= 8'd34) begin
          nonce_d = {nonce_q[23:0], rx_s};
        end else begin
          winner_d = winner_q;
        end
        if (frame_end_s) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          found_d = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      idx_q      <= 8'd0;
      kick_q     <= 1'b0;
      poll_cnt_q <= 16'd0;
      wait_q     <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      timeout_q  <= 1'b0;
      nonce_q    <= 32'd0;
      winner_q   <= 256'd0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      kick_q     <= kick_d;
      poll_cnt_q <= poll_cnt_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      timeout_q  <= timeout_d;
      nonce_q    <= nonce_d;
      winner_q   <= winner_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign timeout  = timeout_q;
  assign nonce    = nonce_q;
  assign winner_H = winner_q;
endmodule

// File: tb/tb_miner_spi_host.sv
// Directed/randomized bench for miner_spi_host with a behavioural SPI miner slave.
module tb_miner_spi_host;
  localparam int CLK_DIV  = 4;
  localparam int BYTE_GAP = 8;
  localparam int POLL_GAP = 16;
  localparam int POLL_MAX = 5;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [255:0] first_stage_hash, prev_blk, winner_H;
  logic [95:0]  input_M;
  logic         busy, done, found, timeout, sck, mosi, ssel;
  logic         miso = 1'b0;
  logic [31:0]  nonce;

  miner_spi_host #(.CLK_DIV(CLK_DIV), .BYTE_GAP(BYTE_GAP), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .first_stage_hash(first_stage_hash),
    .input_M(input_M), .prev_blk(prev_blk), .busy(busy), .done(done), .found(found),
    .timeout(timeout), .nonce(nonce), .winner_H(winner_H), .sck(sck), .mosi(mosi),
    .ssel(ssel), .miso(miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural miner slave ----------------
  logic [7:0] script[$];
  logic [7:0] default_status;
  logic [7:0] rd [36];
  logic [7:0] fb[$];
  logic [7:0] fdata[$];
  int         flen[$];
  int         frames_in_job = 0;
  logic [7:0] s_tx, s_rx, s_status;
  int         s_bit, s_k, byte_start_cyc, mosi_cyc;
  logic       ssel_p = 1'b1;
  logic       sck_p = 1'b0;

  function automatic logic [7:0] resp(input int k);
    if (k < 2) return s_status;
    else if (k < 38) return rd[k-2];
    else return 8'h00;
  endfunction

  always @(mosi) mosi_cyc = cyc;

  always @(negedge clk) if (ssel === 1'b1) begin
    checks++;
    assert (sck === 1'b0) else begin
      errors++;
      $error("FAIL sck_idle: observed sck=%b expected 0 while ssel=1", sck);
    end
  end

  always @(ssel or sck) begin
    if (ssel !== ssel_p) begin
      if (ssel === 1'b0) begin
        fb.delete();
        s_bit = 0; s_k = 0; s_rx = 8'h00;
        if (frames_in_job == 0) s_status = 8'h00;
        else if (script.size() > 0) s_status = script.pop_front();
        else s_status = default_status;
        s_tx = resp(0);
        miso = s_tx[7];
      end else begin
        flen.push_back(fb.size());
        foreach (fb[i]) fdata.push_back(fb[i]);
        frames_in_job++;
      end
    end else if (ssel === 1'b0 && sck !== sck_p) begin
      if (sck === 1'b1) begin
        checks++;
        assert (cyc - mosi_cyc >= CLK_DIV) else begin
          errors++;
          $error("FAIL mosi_setup: observed %0d cycles expected >= %0d", cyc - mosi_cyc, CLK_DIV);
        end
        if (s_bit == 0) begin
          if (s_k > 0) begin
            checks++;
            assert (cyc - byte_start_cyc == 16*CLK_DIV + BYTE_GAP) else begin
              errors++;
              $error("FAIL byte_period: observed %0d expected %0d", cyc - byte_start_cyc, 16*CLK_DIV + BYTE_GAP);
            end
          end
          byte_start_cyc = cyc;
        end
        s_rx = {s_rx[6:0], mosi};
        s_bit++;
        if (s_bit == 8) begin
          fb.push_back(s_rx);
          s_bit = 0;
          s_k++;
        end
      end else begin
        if (s_bit == 0) s_tx = resp(s_k);
        else s_tx = {s_tx[6:0], 1'b0};
        miso = s_tx[7];
      end
    end
    ssel_p = ssel;
    sck_p  = sck;
  end

  // ---------------- helpers and reference model ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] rand_other();
    logic [7:0] st;
    do st = 8'($urandom_range(0, 255)); while (st == 8'hA5 || st == 8'hA6);
    return st;
  endfunction

  task automatic set_result(input logic [255:0] h, input logic [31:0] n);
    for (int i = 0; i < 32; i++) rd[i] = h[255-8*i -: 8];
    for (int j = 0; j < 4; j++) rd[32+j] = n[31-8*j -: 8];
  endtask

  task automatic clear_rec();
    fdata.delete(); flen.delete(); frames_in_job = 0;
  endtask

  // Outcome of a job given the status script the miner will answer with.
  task automatic predict(output int polls, output bit fnd, output bit tmo);
    logic [7:0] st;
    polls = 0; fnd = 1'b0; tmo = 1'b0;
    for (int p = 1; p <= POLL_MAX; p++) begin
      st = (p <= script.size()) ? script[p-1] : default_status;
      polls = p;
      if (st == 8'hA6) begin fnd = 1'b1; break; end
      if (st == 8'hA5) break;
      if (p == POLL_MAX) tmo = 1'b1;
    end
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_busy_on_start"}, 256'(busy), 256'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
    end
    chk({tag, "_done_seen"}, 256'(seen), 256'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_job(input string tag, input logic [255:0] f, input logic [95:0] m,
                           input logic [255:0] p, input int polls, input bit fnd, input bit tmo,
                           input bit chk_res, input logic [31:0] exp_n, input logic [255:0] exp_h,
                           input int dc0);
    logic [7:0] exp_dat[$];
    int         exp_len[$];
    exp_dat.push_back(8'hA2);
    for (int i = 0; i < 32; i++) exp_dat.push_back(f[255-8*i -: 8]);
    for (int i = 0; i < 12; i++) exp_dat.push_back(m[95-8*i -: 8]);
    for (int i = 0; i < 32; i++) exp_dat.push_back(p[255-8*i -: 8]);
    exp_len.push_back(77);
    for (int i = 0; i < polls; i++) begin exp_dat.push_back(8'h00); exp_len.push_back(1); end
    if (fnd) begin
      exp_dat.push_back(8'hA4);
      for (int i = 0; i < 37; i++) exp_dat.push_back(8'h00);
      exp_len.push_back(38);
    end
    chk({tag, "_frames"}, 256'(flen.size()), 256'(exp_len.size()));
    if (flen.size() == exp_len.size())
      foreach (exp_len[i]) chk({tag, "_frame_len"}, 256'(flen[i]), 256'(exp_len[i]));
    chk({tag, "_total_bytes"}, 256'(fdata.size()), 256'(exp_dat.size()));
    if (fdata.size() == exp_dat.size())
      foreach (exp_dat[i]) chk({tag, "_mosi_byte"}, 256'(fdata[i]), 256'(exp_dat[i]));
    chk({tag, "_done_pulses"}, 256'(done_cnt - dc0), 256'd1);
    chk({tag, "_found"}, 256'(found), 256'(fnd));
    chk({tag, "_timeout"}, 256'(timeout), 256'(tmo));
    chk({tag, "_busy_after"}, 256'(busy), 256'd0);
    if (chk_res) begin
      chk({tag, "_nonce"}, 256'(nonce), 256'(exp_n));
      chk({tag, "_winner"}, winner_H, exp_h);
    end
  endtask

  task automatic run_job(input string tag, input logic [255:0] f, input logic [95:0] m,
                         input logic [255:0] p, input bit chk_res, input logic [31:0] exp_n,
                         input logic [255:0] exp_h);
    int polls, dc0;
    bit fnd, tmo;
    predict(polls, fnd, tmo);
    clear_rec();
    dc0 = done_cnt;
    first_stage_hash = f; input_M = m; prev_blk = p;
    pulse_start(tag);
    wait_done(tag);
    check_job(tag, f, m, p, polls, fnd, tmo, chk_res, exp_n, exp_h, dc0);
  endtask

  // ---------------- directed sequence ----------------
  logic [255:0] f0, p0, h0;
  logic [95:0]  m0;
  logic [31:0]  n0;
  int           polls_x, dc_x;
  bit           fnd_x, tmo_x, hit;

  initial begin
    reset = 1'b0; start = 1'b0;
    first_stage_hash = '0; input_M = '0; prev_blk = '0;
    default_status = 8'hA1;
    set_result(256'd0, 32'd0);
    #23;
    chk("rst_ssel", 256'(ssel), 256'd1);
    chk("rst_sck", 256'(sck), 256'd0);
    chk("rst_mosi", 256'(mosi), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_done", 256'(done), 256'd0);
    chk("rst_found", 256'(found), 256'd0);
    chk("rst_timeout", 256'(timeout), 256'd0);
    chk("rst_nonce", 256'(nonce), 256'd0);
    chk("rst_winner", winner_H, 256'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);

    // Not-found straight after reset: results stay zero.
    script = '{8'hA5};
    run_job("notfound", rand256(), 96'(rand256()), rand256(), 1'b1, 32'd0, 256'd0);

    // Found path with ramp data; a start mid-job must be ignored.
    for (int i = 0; i < 32; i++) f0[255-8*i -: 8] = 8'(i);
    for (int i = 0; i < 12; i++) m0[95-8*i -: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 32; i++) p0[255-8*i -: 8] = 8'(8'hFF - i);
    h0 = {{31{8'h11}}, 8'hEE};
    n0 = 32'hDEADBEEF;
    set_result(h0, n0);
    script = '{8'hA1, 8'hA1, 8'hA1, 8'hA6};
    predict(polls_x, fnd_x, tmo_x);
    clear_rec();
    dc_x = done_cnt;
    first_stage_hash = f0; input_M = m0; prev_blk = p0;
    pulse_start("found");
    repeat (6000) @(negedge clk);
    first_stage_hash = rand256();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    first_stage_hash = f0;
    wait_done("found");
    check_job("found", f0, m0, p0, polls_x, fnd_x, tmo_x, 1'b1, n0, h0, dc_x);

    // Timeout: miner keeps answering busy.
    script.delete();
    default_status = 8'hA1;
    run_job("timeout", rand256(), 96'(rand256()), rand256(), 1'b0, 32'd0, 256'd0);

    // Randomized found job with random non-terminal statuses first.
    script.delete();
    for (int i = 0; i < int'($urandom_range(0, 3)); i++) script.push_back(rand_other());
    script.push_back(8'hA6);
    default_status = rand_other();
    h0 = rand256();
    n0 = $urandom;
    set_result(h0, n0);
    run_job("rand_found", rand256(), 96'(rand256()), rand256(), 1'b1, n0, h0);

    // Reset in the middle of the load frame.
    clear_rec();
    dc_x = done_cnt;
    first_stage_hash = rand256();
    pulse_start("midrst");
    hit = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (frames_in_job == 0 && fb.size() >= 40) begin hit = 1'b1; break; end
    end
    chk("midrst_reached_byte40", 256'(hit), 256'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ssel", 256'(ssel), 256'd1);
    chk("midrst_sck", 256'(sck), 256'd0);
    chk("midrst_busy", 256'(busy), 256'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", 256'(done_cnt - dc_x), 256'd0);
    chk("midrst_found", 256'(found), 256'd0);

    // Restart after the abort: full frame beginning with the start command.
    script = '{rand_other(), 8'hA5};
    run_job("restart", rand256(), 96'(rand256()), rand256(), 1'b1, 32'd0, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/miner_spi_host.md
Name: miner_spi_host

Overview:
- SPI master that drives the miner command protocol from the host side.
- Takes one mining job from a local requester and transfers it to the miner's SPI slave with MSG_START plus 76 bytes.
- Polls the miner status byte until a DONE or DONE_FOUND code arrives, then fetches the 32-byte winning hash and the 4-byte nonce with GET_MSG.
- Returns the result to the requester. Used as the on-FPGA host for bench bring-up and for multi-miner controllers.

Parameters:
- CLK_DIV, 4, SCK half-period in clk cycles; must be ≥4.
- BYTE_GAP, 8, clk cycles with SCK low between consecutive bytes inside one frame.
- POLL_GAP, 256, clk cycles with SSEL high between status polls.
- POLL_MAX, 65535, maximum number of polls before timeout; 16-bit counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that launches a job; ignored while busy=1
- first_stage_hash  in  256  job data, sent first, MSB byte first
- input_M  in  96  job data, sent second, MSB byte first
- prev_blk  in  256  job data, sent third, MSB byte first
- busy  out  1  high from the start acceptance cycle until the done pulse
- done  out  1  one-cycle pulse when a job ends
- found  out  1  valid with done; 1 = result fetched
- timeout  out  1  valid with done; 1 = POLL_MAX exceeded
- nonce  out  32  winning nonce; held until the next start
- winner_H  out  256  winning hash; held until the next start
- sck  out  1  SPI clock, idles low
- mosi  out  1  SPI data out, MSB first
- ssel  out  1  SPI select, active low
- miso  in  1  SPI data in

Behaviour:
- Reset (asynchronous, reset=0):
  - ssel=1, sck=0, mosi=0.
  - busy, done, found, timeout = 0.
  - nonce=0, winner_H=0, FSM in IDLE.
  - Asserting reset mid-frame aborts the job immediately with no done pulse.
- SPI mode 0:
  - mosi changes only while sck=0, at least CLK_DIV cycles before the rising edge.
  - miso is sampled in the clk cycle in which sck rises.
  - One byte takes 16*CLK_DIV cycles plus BYTE_GAP cycles.
  - ssel falls CLK_DIV cycles before the first rising edge of a frame and rises CLK_DIV cycles after the last falling edge.
- Byte engine: accepts a tx byte and returns an rx byte plus a byte_done strobe. The main FSM sequences the engine.
- On start (while IDLE), latch all job inputs, set busy=1, clear found and timeout.
- FSM states:
  - IDLE: wait for start.
  - LOAD: one frame of 77 bytes. Byte 0 = 0xA2. Bytes 1–32 = first_stage_hash[255:0]. Bytes 33–44 = input_M[95:0]. Bytes 45–76 = prev_blk[255:0]. Every byte is sent MSB first. rx data is discarded.
  - POLL_WAIT: ssel high for POLL_GAP cycles.
  - POLL: one 1-byte frame with tx=0x00; the rx byte is the miner status. Transitions:
    - 0xA6 → READ.
    - 0xA5 → FINISH with found=0.
    - 0xA0, 0xA1, or any other value → increment poll_cnt. If poll_cnt reaches POLL_MAX → FINISH with timeout=1; otherwise → POLL_WAIT.
  - READ: one frame of 38 bytes. Byte 0 = 0xA4, followed by 37 bytes of 0x00. rx bytes are used as follows:
    - bytes 0–1: discarded (miner pipeline lag).
    - bytes 2–33: shifted into winner_H, MSB first.
    - bytes 34–37: shifted into nonce, MSB first.
    - Then → FINISH with found=1.
  - FINISH: done=1 for one cycle, busy=0, → IDLE. found, timeout, nonce and winner_H hold until the next accepted start.
- Byte and poll counters are 8-bit and 16-bit and never wrap within a job.
- A start that coincides with FINISH is ignored.
- The status byte is captured from the completed 8th rising edge only; partial bytes are never interpreted.

Test Plan:
- Load job: first_stage_hash=0x00..1F byte ramp, input_M=0xA0..AB, prev_blk=0xFF..E0, start pulse → ssel low for exactly 77 bytes. The slave model sees 0xA2, 0x00, 0x01, …, 0x1F, 0xA0, …, 0xAB, 0xFF, …, 0xE0. busy=1 from the start cycle.
- Found path: slave answers 0xA1 for 3 polls, then 0xA6, with hash=0x1111…11EE and nonce=0xDEADBEEF → exactly 4 poll frames, then a 38-byte frame starting 0xA4. done pulses once with found=1, timeout=0, nonce=0xDEADBEEF, winner_H=0x1111…11EE.
- Not-found path: slave answers 0xA5 on the first poll → no 0xA4 frame is sent; done=1 with found=0, timeout=0; nonce and winner_H remain 0.
- Timeout: POLL_MAX=5, slave always returns 0xA1 → exactly 5 polls, then done=1 with timeout=1, found=0.
- Timing: CLK_DIV=4, BYTE_GAP=8 → each byte occupies 72 clk cycles, mosi is stable across every rising sck edge, and sck=0 whenever ssel=1.
- Reset mid-LOAD at byte 40 → ssel=1 and sck=0 asynchronously, no done pulse. A subsequent start restarts with 0xA2.
